// File: rtl/display_driver.sv
// display_driver: iterative double-dabble binary-to-BCD converter feeding a multiplexed 4-digit 7-segment display
module display_driver #(
    parameter int REFRESH_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  value,
    output logic [6:0]  seg,
    output logic [3:0]  dig_en,
    output logic [15:0] bcd,
    output logic        busy
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [RW-1:0] LAST = RW'(REFRESH_DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_next;
    logic [25:0]   sr, shifted;
    logic [3:0]    iter;
    logic [9:0]    last_value;
    logic          start, done;
    logic [RW-1:0] refresh;
    logic [1:0]    idx;
    logic [3:0]    digit;
    logic          blank;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'd0:    font = 7'h3F;
            4'd1:    font = 7'h06;
            4'd2:    font = 7'h5B;
            4'd3:    font = 7'h4F;
            4'd4:    font = 7'h66;
            4'd5:    font = 7'h6D;
            4'd6:    font = 7'h7D;
            4'd7:    font = 7'h07;
            4'd8:    font = 7'h7F;
            4'd9:    font = 7'h6F;
            default: font = 7'h00;
        endcase
    endfunction

    // Converter state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Start a conversion on a changed input; finish after the tenth shift
    always_comb begin
        state_next = state;
        start      = 1'b0;
        done       = 1'b0;
        if (state == IDLE) begin
            if (value != last_value) begin
                start      = 1'b1;
                state_next = SHIFT;
            end
        end else if (iter == 4'd9) begin
            done       = 1'b1;
            state_next = IDLE;
        end
    end

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left
    always_comb begin
        shifted = sr;
        for (int i = 0; i < 4; i++)
            if (sr[10+4*i +: 4] >= 4'd5) shifted[10+4*i +: 4] = sr[10+4*i +: 4] + 4'd3;
        shifted = {shifted[24:0], 1'b0};
    end

    // Converter datapath; bcd is written only with a finished result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr         <= '0;
            iter       <= '0;
            last_value <= '0;
            busy       <= 1'b0;
            bcd        <= '0;
        end else if (start) begin
            sr         <= {16'b0, value};
            last_value <= value;
            busy       <= 1'b1;
            iter       <= '0;
        end else if (state == SHIFT) begin
            sr   <= shifted;
            iter <= iter + 4'd1;
            if (done) begin
                bcd  <= shifted[25:10];
                busy <= 1'b0;
            end
        end
    end

    // Select the current digit and blank leading zeros above the units place
    always_comb begin
        digit = bcd[4*idx +: 4];
        blank = (idx == 2'd3) ? (bcd[15:12] == 4'd0) :
                (idx == 2'd2) ? (bcd[15:8] == 8'd0) :
                (idx == 2'd1) ? (bcd[15:4] == 12'd0) : 1'b0;
    end

    // Refresh timer, digit rotation and registered segment/enable outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh <= '0;
            idx     <= '0;
            dig_en  <= '0;
            seg     <= '0;
        end else begin
            refresh <= (refresh == LAST) ? '0 : refresh + RW'(1);
            if (refresh == LAST) idx <= idx + 2'd1;
            dig_en  <= 4'b0001 << idx;
            seg     <= blank ? 7'h00 : font(digit);
        end
    end
endmodule

// File: tb/tb_display_driver.sv
// tb_display_driver: directed scenario tests for display_driver with REFRESH_DIV=4
module tb_display_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  value = '0;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [15:0] bcd;
    logic        busy;
    int checks = 0;
    int fails = 0;

    display_driver #(.REFRESH_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .value(value),
        .seg(seg), .dig_en(dig_en), .bcd(bcd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic scan_display(output logic [3:0][6:0] seen, output logic onehot_ok);
        seen = '0;
        onehot_ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step(1);
            if (!$onehot(dig_en)) onehot_ok = 1'b0;
            for (int i = 0; i < 4; i++) if (dig_en[i]) seen[i] = seg;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        value = 10'd0;
        step(2);
        checks++; if (seg !== 7'h00)    begin fails++; $display("FAIL reset_seg: got %h expected 00", seg); end
        checks++; if (dig_en !== 4'h0)  begin fails++; $display("FAIL reset_dig_en: got %b expected 0000", dig_en); end
        checks++; if (bcd !== 16'h0000) begin fails++; $display("FAIL reset_bcd: got %h expected 0000", bcd); end
        checks++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_mux;
        logic [3:0] exp_en;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp_en = 4'b0001 << ((k - 1) / 4);
            checks++; if (dig_en !== exp_en) begin fails++; $display("FAIL mux_dig_en[%0d]: got %b expected %b", k, dig_en, exp_en); end
            checks++; if (seg !== (k <= 4 ? 7'h3F : 7'h00)) begin fails++; $display("FAIL mux_seg[%0d]: got %h expected %h", k, seg, (k <= 4 ? 7'h3F : 7'h00)); end
            checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mux_busy[%0d]: got %b expected 0", k, busy); end
        end
    endtask

    task automatic test_1023;
        logic [3:0][6:0] seen;
        logic oh;
        value = 10'd1023;
        for (int k = 1; k <= 11; k++) begin
            step(1);
            checks++; if (busy !== (k < 11)) begin fails++; $display("FAIL c1023_busy[%0d]: got %b expected %b", k, busy, (k < 11)); end
            checks++; if (bcd !== (k < 11 ? 16'h0000 : 16'h1023)) begin fails++; $display("FAIL c1023_bcd[%0d]: got %h expected %h", k, bcd, (k < 11 ? 16'h0000 : 16'h1023)); end
        end
        scan_display(seen, oh);
        checks++; if (oh !== 1'b1)       begin fails++; $display("FAIL c1023_onehot: got %b expected 1", oh); end
        checks++; if (seen[3] !== 7'h06) begin fails++; $display("FAIL c1023_thou: got %h expected 06", seen[3]); end
        checks++; if (seen[2] !== 7'h3F) begin fails++; $display("FAIL c1023_hund: got %h expected 3F", seen[2]); end
        checks++; if (seen[1] !== 7'h5B) begin fails++; $display("FAIL c1023_tens: got %h expected 5B", seen[1]); end
        checks++; if (seen[0] !== 7'h4F) begin fails++; $display("FAIL c1023_unit: got %h expected 4F", seen[0]); end
    endtask

    task automatic test_100;
        logic [3:0][6:0] seen;
        logic oh;
        value = 10'd100;
        for (int k = 1; k <= 11; k++) begin
            step(1);
            checks++; if (bcd !== (k < 11 ? 16'h1023 : 16'h0100)) begin fails++; $display("FAIL c100_bcd[%0d]: got %h expected %h", k, bcd, (k < 11 ? 16'h1023 : 16'h0100)); end
        end
        scan_display(seen, oh);
        checks++; if (oh !== 1'b1)       begin fails++; $display("FAIL c100_onehot: got %b expected 1", oh); end
        checks++; if (seen[3] !== 7'h00) begin fails++; $display("FAIL c100_thou: got %h expected 00", seen[3]); end
        checks++; if (seen[2] !== 7'h06) begin fails++; $display("FAIL c100_hund: got %h expected 06", seen[2]); end
        checks++; if (seen[1] !== 7'h3F) begin fails++; $display("FAIL c100_tens: got %h expected 3F", seen[1]); end
        checks++; if (seen[0] !== 7'h3F) begin fails++; $display("FAIL c100_unit: got %h expected 3F", seen[0]); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_bcd;
        logic exp_busy;
        value = 10'd5;
        for (int k = 1; k <= 22; k++) begin
            step(1);
            exp_bcd  = (k <= 10) ? 16'h0100 : (k <= 21) ? 16'h0005 : 16'h0999;
            exp_busy = (k <= 10) || (k >= 12 && k <= 21);
            checks++; if (bcd !== exp_bcd)   begin fails++; $display("FAIL b2b_bcd[%0d]: got %h expected %h", k, bcd, exp_bcd); end
            checks++; if (busy !== exp_busy) begin fails++; $display("FAIL b2b_busy[%0d]: got %b expected %b", k, busy, exp_busy); end
            if (k == 3) value = 10'd999;
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0][6:0] seen;
        logic oh;
        value = 10'd512;
        step(5);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_pre: got %b expected 1", busy); end
        rst_n = 1'b0;
        step(1);
        checks++; if (bcd !== 16'h0000) begin fails++; $display("FAIL mid_bcd: got %h expected 0000", bcd); end
        checks++; if (busy !== 1'b0)    begin fails++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (dig_en !== 4'h0)  begin fails++; $display("FAIL mid_dig_en: got %b expected 0000", dig_en); end
        checks++; if (seg !== 7'h00)    begin fails++; $display("FAIL mid_seg: got %h expected 00", seg); end
        rst_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step(1);
            checks++; if (busy !== (k < 11)) begin fails++; $display("FAIL c512_busy[%0d]: got %b expected %b", k, busy, (k < 11)); end
            checks++; if (bcd !== (k < 11 ? 16'h0000 : 16'h0512)) begin fails++; $display("FAIL c512_bcd[%0d]: got %h expected %h", k, bcd, (k < 11 ? 16'h0000 : 16'h0512)); end
        end
        scan_display(seen, oh);
        checks++; if (oh !== 1'b1)       begin fails++; $display("FAIL c512_onehot: got %b expected 1", oh); end
        checks++; if (seen[3] !== 7'h00) begin fails++; $display("FAIL c512_thou: got %h expected 00", seen[3]); end
        checks++; if (seen[2] !== 7'h6D) begin fails++; $display("FAIL c512_hund: got %h expected 6D", seen[2]); end
        checks++; if (seen[1] !== 7'h06) begin fails++; $display("FAIL c512_tens: got %h expected 06", seen[1]); end
        checks++; if (seen[0] !== 7'h5B) begin fails++; $display("FAIL c512_unit: got %h expected 5B", seen[0]); end
    endtask

    task automatic test_wrap_hold;
        logic [3:0][6:0] seen;
        logic oh;
        value = 10'd0;
        step(11);
        checks++; if (bcd !== 16'h0000) begin fails++; $display("FAIL zero_bcd: got %h expected 0000", bcd); end
        scan_display(seen, oh);
        checks++; if (seen !== {7'h00, 7'h00, 7'h00, 7'h3F}) begin fails++; $display("FAIL zero_display: got %h expected 00000003F", seen); end
        value = 10'd1023;
        step(11);
        checks++; if (bcd !== 16'h1023) begin fails++; $display("FAIL wrap_bcd: got %h expected 1023", bcd); end
        for (int k = 1; k <= 30; k++) begin
            step(1);
            checks++; if (busy !== 1'b0)    begin fails++; $display("FAIL hold_busy[%0d]: got %b expected 0", k, busy); end
            checks++; if (bcd !== 16'h1023) begin fails++; $display("FAIL hold_bcd[%0d]: got %h expected 1023", k, bcd); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_mux();
        test_1023();
        test_100();
        test_back_to_back();
        test_reset_mid();
        test_wrap_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
